// File: rtl/config_source_arbiter.sv
// Arbitrates configuration-bitstream sources onto a single config port.
// Fixed priority (index 0 highest); the owner keeps the port until done_i or a stall timeout.
module config_source_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 12000000
) (
    input  logic                          clk_system_i,
    input  logic                          reset_n_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            word_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] word_i,
    input  logic [NUM_REQ-1:0]            done_i,
    output logic [NUM_REQ-1:0]            ready_o,
    output logic [DATA_WIDTH-1:0]         cfg_word_o,
    output logic                          cfg_valid_o,
    input  logic                          cfg_ready_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o,
    output logic                          config_done_o,
    output logic                          timeout_o
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, RELEASE} state_t;

    state_t                 state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [NUM_REQ-1:0]     pick;
    logic [DATA_WIDTH-1:0]  sel_word;
    logic [DATA_WIDTH-1:0]  word_q;
    logic                   valid_q;
    logic [CNT_W-1:0]       stall_q;
    logic                   armed_q;
    logic                   timed_out_q;
    logic                   done_pulse_q, timeout_pulse_q;
    logic                   go_done, go_timeout;
    logic                   hs, done_g, stall_hit;

    // Lowest asserted request index wins.
    always_comb begin
        pick = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                pick    = '0;
                pick[k] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_q[k]) sel_word = word_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign ready_o   = (state_q == ACTIVE) ? (grant_q & {NUM_REQ{~valid_q | cfg_ready_i}}) : '0;
    assign hs        = |(word_valid_i & ready_o);
    assign done_g    = |(done_i & grant_q);
    assign stall_hit = (stall_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_system_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        go_done    = 1'b0;
        go_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (armed_q && |req_i) begin
                    grant_d = pick;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (done_g) begin
                    state_d = RELEASE;
                end else if (!hs && stall_hit) begin
                    state_d    = RELEASE;
                    go_timeout = 1'b1;
                end
            end
            RELEASE: begin
                // Leave only once the last accepted word has been taken by the config port.
                if (!valid_q) begin
                    state_d = IDLE;
                    grant_d = '0;
                    go_done = ~timed_out_q;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_system_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            word_q          <= '0;
            valid_q         <= 1'b0;
            stall_q         <= '0;
            armed_q         <= 1'b0;
            timed_out_q     <= 1'b0;
            done_pulse_q    <= 1'b0;
            timeout_pulse_q <= 1'b0;
        end else begin
            armed_q         <= 1'b1;
            done_pulse_q    <= go_done;
            timeout_pulse_q <= go_timeout;

            if (hs) begin
                word_q  <= sel_word;
                valid_q <= 1'b1;
            end else if (cfg_ready_i) begin
                valid_q <= 1'b0;
            end

            if (state_q != ACTIVE || hs) stall_q <= '0;
            else if (stall_q != '1)      stall_q <= stall_q + 1'b1;

            if (go_timeout)          timed_out_q <= 1'b1;
            else if (state_q == IDLE) timed_out_q <= 1'b0;
        end
    end

    assign cfg_word_o    = word_q;
    assign cfg_valid_o   = valid_q;
    assign grant_o       = grant_q;
    assign busy_o        = (state_q != IDLE);
    assign config_done_o = done_pulse_q;
    assign timeout_o     = timeout_pulse_q;

endmodule

// File: tb/tb_config_source_arbiter.sv
// Scoreboard bench for config_source_arbiter: accepted words are queued by the driver
// and popped by a negedge monitor whenever the config port takes a word.
module tb_config_source_arbiter;
    localparam int NR = 3;
    localparam int DW = 32;
    localparam int TO = 8;

    logic             clk_system_i = 1'b0;
    logic             reset_n_i;
    logic [NR-1:0]    req_i, word_valid_i, done_i, ready_o, grant_o;
    logic [NR*DW-1:0] word_i;
    logic [DW-1:0]    cfg_word_o;
    logic             cfg_valid_o, cfg_ready_i, busy_o, config_done_o, timeout_o;

    config_source_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_system_i(clk_system_i), .reset_n_i(reset_n_i), .req_i(req_i),
        .word_valid_i(word_valid_i), .word_i(word_i), .done_i(done_i), .ready_o(ready_o),
        .cfg_word_o(cfg_word_o), .cfg_valid_o(cfg_valid_o), .cfg_ready_i(cfg_ready_i),
        .grant_o(grant_o), .busy_o(busy_o), .config_done_o(config_done_o), .timeout_o(timeout_o)
    );

    always #5 clk_system_i = ~clk_system_i;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int n_tout   = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_system_i);
        #1;
    endtask

    // Monitor: scoreboard pop, hold-stability under backpressure, pulse counting.
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_word = '0;
    always @(negedge clk_system_i) begin
        if (!reset_n_i) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", cfg_valid_o, 1'b1);
                check("hold_word", cfg_word_o, prev_word);
            end
            if (cfg_valid_o && cfg_ready_i) begin
                if (exp_q.size() == 0) check("sb_underflow", 0, 1);
                else check("sb_word", cfg_word_o, exp_q.pop_front());
            end
            check("ready_nongrant", ready_o & ~grant_o, '0);
            if (config_done_o) n_done++;
            if (timeout_o) n_tout++;
            prev_hold = cfg_valid_o && !cfg_ready_i;
            prev_word = cfg_word_o;
        end
    end

    function automatic int lowest(input logic [NR-1:0] r);
        int g = -1;
        for (int k = NR - 1; k >= 0; k--) if (r[k]) g = k;
        return g;
    endfunction

    task automatic wait_grant(input logic [NR-1:0] exp, output int lat);
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_system_i);
            if (grant_o != '0) break;
            step();
            lat++;
        end
        check("grant", grant_o, exp);
        step();
    endtask

    task automatic wait_done();
        int found = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_system_i);
            if (config_done_o) begin found = 1; break; end
            step();
        end
        check("done_seen", found, 1);
        check("done_grant0", grant_o, '0);
        check("done_idle", busy_o, 1'b0);
        step();
    endtask

    task automatic pulse_done(input int g);
        done_i[g] = 1'b1;
        step();
        done_i = '0;
    endtask

    // Drives n words from requester g; each word is pushed to the scoreboard when handshaken.
    task automatic send_words(input int g, input int n, input logic [DW-1:0] base,
                              input bit rnd, input bit done_last);
        int idx = 0, cyc = 0, lowcnt = 0;
        logic [DW-1:0] cur;
        cur = rnd ? $urandom : base;
        while (idx < n && cyc < 200) begin
            word_valid_i = '0;
            done_i       = '0;
            if (rnd) begin
                for (int k = 0; k < NR; k++) begin
                    if (k != g) begin
                        word_valid_i[k]         = 1'($urandom);
                        word_i[k*DW +: DW]      = $urandom;
                        done_i[k]               = ($urandom_range(0, 3) == 0);
                    end
                end
                cfg_ready_i = (lowcnt >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
            end else begin
                cfg_ready_i = 1'b1;
            end
            word_valid_i[g]    = 1'b1;
            word_i[g*DW +: DW] = cur;
            if (done_last && idx == n - 1) begin
                cfg_ready_i = 1'b1;
                done_i[g]   = 1'b1;
            end
            lowcnt = cfg_ready_i ? 0 : lowcnt + 1;
            @(negedge clk_system_i);
            if (ready_o[g]) begin
                exp_q.push_back(cur);
                idx++;
                cur = rnd ? $urandom : base + DW'(idx);
            end
            cyc++;
            step();
        end
        word_valid_i = '0;
        done_i       = '0;
        check("send_count", idx, n);
        if (!rnd) check("throughput", cyc, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, g, d0, t0;
        logic [NR-1:0] r;
        reset_n_i = 1'b0; req_i = '0; word_valid_i = '0; word_i = '0; done_i = '0; cfg_ready_i = 1'b1;
        #3;
        check("rst_grant", grant_o, '0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_valid", cfg_valid_o, 1'b0);
        check("rst_word", cfg_word_o, '0);
        check("rst_ready", ready_o, '0);
        repeat (2) @(posedge clk_system_i);
        #1 reset_n_i = 1'b1;
        step(); step();

        // Single stream from requester 1.
        req_i = 3'b010;
        wait_grant(3'b010, lat);
        check("grant_lat", lat, 1);
        req_i = '0;
        send_words(1, 4, 32'hA0, 0, 0);
        pulse_done(1);
        wait_done();

        // Contention: 1 wins over 2, late request from 0 waits for release.
        req_i = 3'b110;
        wait_grant(3'b010, lat);
        send_words(1, 2, 32'h10, 0, 0);
        req_i = 3'b111;
        send_words(1, 2, 32'h12, 0, 0);
        @(negedge clk_system_i);
        check("contention_hold", grant_o, 3'b010);
        step();
        req_i = 3'b001;
        pulse_done(1);
        wait_done();
        @(negedge clk_system_i);
        check("contention_next", grant_o, 3'b001);
        step();
        req_i = '0;
        pulse_done(0);
        wait_done();

        // Backpressure with 0xB0 pending.
        req_i = 3'b100;
        wait_grant(3'b100, lat);
        req_i = '0;
        send_words(2, 1, 32'hB0, 0, 0);
        cfg_ready_i = 1'b0;
        word_valid_i[2] = 1'b1;
        word_i[2*DW +: DW] = 32'hB1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_system_i);
            check("bp_word", cfg_word_o, 32'hB0);
            check("bp_ready", ready_o[2], 1'b0);
            step();
        end
        send_words(2, 3, 32'hB1, 0, 0);
        pulse_done(2);
        wait_done();

        // Done while a word is still pending on the config port.
        req_i = 3'b100;
        wait_grant(3'b100, lat);
        req_i = '0;
        send_words(2, 1, 32'hC0, 0, 0);
        cfg_ready_i = 1'b0;
        pulse_done(2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_system_i);
            check("rel_busy", busy_o, 1'b1);
            check("rel_nodone", config_done_o, 1'b0);
            step();
        end
        cfg_ready_i = 1'b1;
        wait_done();

        // Timeout: one word then silence.
        d0 = n_done;
        req_i = 3'b001;
        wait_grant(3'b001, lat);
        req_i = '0;
        send_words(0, 1, 32'hD0, 0, 0);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_system_i);
            if (timeout_o) break;
            step();
            lat++;
        end
        check("timeout_delay", lat, TO);
        step();
        @(negedge clk_system_i);
        check("timeout_pulse1", timeout_o, 1'b0);
        check("timeout_grant0", grant_o, '0);
        check("timeout_nodone", n_done, d0);
        step();

        // Random streams from random contention patterns.
        for (int rr = 0; rr < 8; rr++) begin
            r = NR'($urandom_range(1, 7));
            g = lowest(r);
            req_i = r;
            wait_grant(NR'(1) << g, lat);
            req_i = '0;
            send_words(g, $urandom_range(3, 10), '0, 1, 1);
            cfg_ready_i = 1'b1;
            wait_done();
        end

        // Reset mid-transfer with a word pending.
        d0 = n_done; t0 = n_tout;
        req_i = 3'b010;
        wait_grant(3'b010, lat);
        cfg_ready_i = 1'b0;
        word_valid_i[1] = 1'b1;
        word_i[1*DW +: DW] = 32'hE0;
        step();
        word_valid_i = '0;
        @(negedge clk_system_i);
        check("pre_rst_valid", cfg_valid_o, 1'b1);
        @(posedge clk_system_i);
        #3 reset_n_i = 1'b0;
        #1;
        check("arst_valid", cfg_valid_o, 1'b0);
        check("arst_word", cfg_word_o, '0);
        check("arst_grant", grant_o, '0);
        check("arst_busy", busy_o, 1'b0);
        check("arst_ready", ready_o, '0);
        cfg_ready_i = 1'b1;
        repeat (2) @(posedge clk_system_i);
        #1 reset_n_i = 1'b1;
        wait_grant(3'b010, lat);
        check("rst_grant_late", lat >= 2, 1'b1);
        check("rst_no_done", n_done, d0);
        check("rst_no_tout", n_tout, t0);
        req_i = '0;
        pulse_done(1);
        wait_done();

        check("sb_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
